// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency 33 cycles from accepted start to done; start is ignored while busy (no queuing).
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a_mag;
  logic [WIDTH-1:0]     r_b_mag;
  logic [WIDTH-1:0]     r_a_orig;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_b_zero;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dbz;

  // Operand conditioning: op[0]=0 selects the signed variants.
  logic             w_signed_op;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_signed_op = ~op[0];
  assign w_sign_a    = w_signed_op & operand_a[WIDTH-1];
  assign w_sign_b    = w_signed_op & operand_b[WIDTH-1];
  assign w_a_mag     = w_sign_a ? (~operand_a + 1'b1) : operand_a;
  assign w_b_mag     = w_sign_b ? (~operand_b + 1'b1) : operand_b;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: the shifted partial remainder needs WIDTH+1 bits for the compare,
  // but a successful subtraction always leaves a result below the divisor.
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_ge   = (r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_b_mag});
  assign w_div_diff = r_acc[2*WIDTH-2:WIDTH-1] - r_b_mag;
  assign w_div_next = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};

  // Sign fix-up of the finished magnitude result.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sign_a ^ r_sign_b) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= 2'b00;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_a_orig <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_a_orig <= operand_a;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_b_zero <= (operand_b == '0);
            r_count  <= CW'(WIDTH);
            r_acc    <= (op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag});
            r_state  <= ST_CALC;
          end else begin
            if (write_hi) r_hi <= write_data;
            if (write_lo) r_lo <= write_data;
          end
        end
        ST_CALC: begin
          r_acc   <= r_op[1] ? w_div_next : w_mul_next;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) r_state <= ST_SIGN;
        end
        ST_SIGN: begin
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_b_zero) begin
            r_hi  <= r_a_orig;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit; inputs driven and outputs sampled on negedge.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        write_hi = 1'b0;
  logic        write_lo = 1'b0;
  logic [31:0] write_data = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  int lat;
  int n_done;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next posedge; returns at the negedge where done is seen (or budget expires).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max*max, with latency and busy/done shape
    op = OP_MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("multu_busy_after_e0", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 20) check("multu_hi_hold_calc", hi, 32'd0);
    end
    check("multu_latency", lat, 32'd33);
    check("multu_busy_in_done", {31'b0, busy}, 32'd0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);
    check("multu_done_one_cycle", {31'b0, done}, 32'd0);

    // Signed multiplies
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_op(OP_MULT, 32'd7, 32'd6, lat);
    check("mult_pos_hi", hi, 32'd0);
    check("mult_pos_lo", lo, 32'd42);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mult_negneg_hi", hi, 32'd0);
    check("mult_negneg_lo", lo, 32'd1);

    // Divides
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'd1);
    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    check("divu_latency", lat, 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_dbz", {31'b0, div_by_zero}, 32'd0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("divu_max_lo", lo, 32'd1);
    check("divu_max_hi", hi, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // Divide by zero
    run_op(OP_DIVU, 32'd100, 32'd0, lat);
    check("divu0_done", {31'b0, done}, 32'd1);
    check("divu0_dbz", {31'b0, div_by_zero}, 32'd1);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd100);
    @(negedge clk);
    check("divu0_dbz_clear", {31'b0, div_by_zero}, 32'd0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat);
    check("div0_dbz", {31'b0, div_by_zero}, 32'd1);
    check("div0_hi", hi, 32'hFFFF_FFF9);
    check("div0_lo", lo, 32'hFFFF_FFFF);

    // Start re-pulsed at cycle 10 of a MULT is ignored
    op = OP_MULT; operand_a = 32'd7; operand_b = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    n_done = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        op = OP_MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        n_done++;
        if (lat == 0) lat = c;
      end
    end
    check("ignore_done_count", n_done, 32'd1);
    check("ignore_latency", lat, 32'd33);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd42);

    // MTHI while idle, MTLO while busy, both together, start beats writes
    write_hi = 1'b1; write_data = 32'h0000_1234;
    @(negedge clk);
    write_hi = 1'b0;
    check("mthi_idle", hi, 32'h0000_1234);
    check("mthi_lo_untouched", lo, 32'd42);
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hA5A5_5A5A;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0;
    check("mthilo_hi", hi, 32'hA5A5_5A5A);
    check("mthilo_lo", lo, 32'hA5A5_5A5A);
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    write_hi = 1'b1; write_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0;
    check("start_wins_hi", hi, 32'hA5A5_5A5A);
    write_lo = 1'b1; write_data = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    write_lo = 1'b0;
    check("mtlo_busy_lo", lo, 32'hA5A5_5A5A);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("after_busy_write_lo", lo, 32'd14);
    check("after_busy_write_hi", hi, 32'd2);

    // Asynchronous reset at cycle 15 of a DIV
    op = OP_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("arst_no_done", n_done, 32'd0);
    check("arst_idle_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
